// File: rtl/inst_decode_stage.sv
// MIPS decode stage: decodes Fetch words into fields and controls, held in a 2-entry FIFO.
// Define DECODE_ILLEGAL_TRAP_EN to flag unsupported opcode/funct on the illegal output.

// Generic synchronous FIFO with a clear input; DEPTH must be a power of two.
// Latency: a pushed word is readable on pop_dat the edge after the push.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         push,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop,
    output logic [W-1:0]                 pop_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr];
endmodule

// Decodes one instruction per accepted word and queues the decoded entry.
// Latency: 1 cycle from accept into an empty buffer to out_valid.
// Backpressure: in_ready is registered and drops while both entries are occupied.
module inst_decode_stage #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       Instruction,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [31:0]       imm_ext,
    output logic [25:0]       jump_target,
    output logic              Jump,
    output logic              Branch,
    output logic              RegWrite,
    output logic              RegDst,
    output logic              ALUSrc,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              MemToReg,
    output logic [3:0]        alu_op,
    output logic              illegal
);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_SLL = 4'd5
    } alu_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [4:0]        shamt;
        logic [31:0]       imm_ext;
        logic [25:0]       jump_target;
        logic              jump;
        logic              branch;
        logic              reg_write;
        logic              reg_dst;
        logic              alu_src;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        alu_t              alu_op;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic              illegal;
`endif
    } entry_t;

    logic [5:0]    opcode;
    logic [5:0]    funct;
    entry_t        dec;
    entry_t        head;
    entry_t        shown;
    logic          accept;
    logic          pop;
    logic [CW-1:0] count;
    logic [CW-1:0] cnt_nxt;

    assign opcode = Instruction[31:26];
    assign funct  = Instruction[5:0];

    always_comb begin
        dec             = '0;
        dec.pc          = pc_in;
        dec.rs          = Instruction[25:21];
        dec.rt          = Instruction[20:16];
        dec.rd          = Instruction[15:11];
        dec.shamt       = Instruction[10:6];
        dec.imm_ext     = {{16{Instruction[15]}}, Instruction[15:0]};
        dec.jump_target = Instruction[25:0];
        dec.alu_op      = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                dec.reg_write = 1'b1;
                dec.reg_dst   = 1'b1;
                case (funct)
                    F_ADD:   dec.alu_op = ALU_ADD;
                    F_SUB:   dec.alu_op = ALU_SUB;
                    F_AND:   dec.alu_op = ALU_AND;
                    F_OR:    dec.alu_op = ALU_OR;
                    F_SLT:   dec.alu_op = ALU_SLT;
                    F_SLL:   dec.alu_op = ALU_SLL;
                    default: begin
                        dec.reg_write = 1'b0;
                        dec.reg_dst   = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            OP_ANDI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_AND;
                dec.imm_ext   = {16'h0000, Instruction[15:0]};
            end
            OP_ORI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_OR;
                dec.imm_ext   = {16'h0000, Instruction[15:0]};
            end
            OP_LW: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec.branch = 1'b1;
                dec.alu_op = ALU_SUB;
            end
            OP_J:    dec.jump = 1'b1;
            default: ;
        endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
        dec.illegal = (opcode == OP_RTYPE)
            ? !(funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL})
            : !(opcode inside {OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW});
`endif
    end

    // flush outranks both sides of the handshake and drops the same-cycle input
    assign accept  = in_valid && in_ready && !flush;
    assign pop     = out_valid && out_ready && !flush;
    assign cnt_nxt = count + CW'(accept) - CW'(pop);

    sync_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (Clock),
        .rst      (Reset),
        .clr      (flush),
        .push     (accept),
        .push_dat (dec),
        .pop      (pop),
        .pop_dat  (head),
        .count    (count)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            in_ready <= 1'b0;
        end else if (flush) begin
            in_ready <= 1'b1;
        end else begin
            in_ready <= (cnt_nxt < CW'(DEPTH));
        end
    end

    assign out_valid = (count != '0);
    assign shown     = out_valid ? head : '0;

    assign pc_out      = shown.pc;
    assign rs          = shown.rs;
    assign rt          = shown.rt;
    assign rd          = shown.rd;
    assign shamt       = shown.shamt;
    assign imm_ext     = shown.imm_ext;
    assign jump_target = shown.jump_target;
    assign Jump        = shown.jump;
    assign Branch      = shown.branch;
    assign RegWrite    = shown.reg_write;
    assign RegDst      = shown.reg_dst;
    assign ALUSrc      = shown.alu_src;
    assign MemRead     = shown.mem_read;
    assign MemWrite    = shown.mem_write;
    assign MemToReg    = shown.mem_to_reg;
    assign alu_op      = shown.alu_op;

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign illegal = shown.illegal;
`else
    assign illegal = 1'b0;
`endif
endmodule
